// File: rtl/jt49_bus_seq.sv
// jt49_bus_seq: queues host register requests and replays them as BDIR/BC1 bus cycles.
// Build option JT49_BUS_SEQ_SKIPLATCH_EN skips the address latch when the address repeats.
module jt49_bus_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] din,
    input  logic [7:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    // state   | meaning
    // S_IDLE  | pins 00, waiting for a queued request
    // S_LATCH | pins 11, din = {0, addr}, held HOLD cycles
    // S_GAP1  | pins 00, one cycle between address and data phase
    // S_WRITE | pins 10, din = data, held HOLD cycles
    // S_READ  | pins 01, dout captured on the last cycle
    // S_GAP2  | pins 00, one cycle before returning to idle
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_GAP1  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_GAP2  = 3'd5
    } state_t;

    logic [12:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop, skip_hit;
    logic [12:0]   head;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   work_q, work_d;
    logic          bdir_q, bdir_d, bc1_q, bc1_d;
    logic [7:0]    din_q, din_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign push       = req_valid && !fifo_full;

    assign req_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign bdir       = bdir_q;
    assign bc1        = bc1_q;
    assign din        = din_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {req_rd, req_addr, req_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
    logic [3:0] last_addr_q, last_addr_d;
    logic       last_valid_q, last_valid_d;

    assign skip_hit = last_valid_q && (head[11:8] == last_addr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_addr_q  <= 4'hF;
            last_valid_q <= 1'b0;
        end else begin
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            bdir_q     <= 1'b0;
            bc1_q      <= 1'b0;
            din_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            bdir_q     <= bdir_d;
            bc1_q      <= bc1_d;
            din_q      <= din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        pop        = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    work_d  = head;
                    cnt_d   = HOLD_LAST;
                    state_d = skip_hit ? S_GAP1 : S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP1;
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
                    last_addr_d  = work_q[11:8];
                    last_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP1: begin
                cnt_d   = HOLD_LAST;
                state_d = work_q[12] ? S_READ : S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == '0) state_d = S_GAP2;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    state_d    = S_GAP2;
                    rd_valid_d = 1'b1;
                    rd_data_d  = dout;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pins follow the state being entered so they line up with the occupied state.
        bdir_d = 1'b0;
        bc1_d  = 1'b0;
        din_d  = '0;
        case (state_d)
            S_LATCH: begin
                bdir_d = 1'b1;
                bc1_d  = 1'b1;
                din_d  = {4'h0, work_d[11:8]};
            end
            S_WRITE: begin
                bdir_d = 1'b1;
                din_d  = work_d[7:0];
            end
            S_READ:  bc1_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jt49_bus_seq.sv
// Bench for jt49_bus_seq: mock PSG register file on the pins, request scoreboard, pin-run monitor.
module tb_jt49_bus_seq;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rd = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       bdir, bc1;
    logic [7:0] din;
    logic [7:0] dout;

    jt49_bus_seq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_addr(req_addr), .req_data(req_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .bdir(bdir), .bc1(bc1), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Mock of the chip behind the wrapper: latches on 11, writes on 10, dout mirrors the latched register.
    logic [7:0] wrap_regs [16];
    logic [3:0] wrap_addr = '0;
    assign dout = wrap_regs[wrap_addr];

    always @(negedge clk) begin
        if ({bdir, bc1} == 2'b11)      wrap_addr = din[3:0];
        else if ({bdir, bc1} == 2'b10) wrap_regs[wrap_addr] = din;
    end

    // Reference model: requests execute in order, so expectations are fixed at acceptance.
    typedef struct packed {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic       skip;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_regs [16];
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
    logic [3:0] m_last_addr = 4'hF;
    logic       m_last_valid = 1'b0;
`endif

    task automatic model_accept(input logic rd, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.rd   = rd;
        e.addr = a;
        e.data = rd ? model_regs[a] : d;
        if (!rd) model_regs[a] = d;
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
        e.skip = m_last_valid && (m_last_addr == a);
        m_last_addr  = a;
        m_last_valid = 1'b1;
`else
        e.skip = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: splits the pin stream into runs of equal {bdir,bc1} and checks each run.
    bit         mon_en = 1'b0;
    bit         btb_mode = 1'b0;
    logic [1:0] cur, run_code, prev_pins, last_active;
    logic [7:0] run_din;
    bit         din_stable, latched;
    int         run_len = 0, gap_len = 0;
    int         lat_cnt = 0, rdv_cnt = 0;
    exp_t       cur_e;

    task close_run();
        case (run_code)
            2'b11: begin
                lat_cnt++;
                chk("latch_len", 32'(run_len), 32'(HOLD));
                if (exp_q.size() == 0) chk("latch_unexpected", 32'(exp_q.size()), 32'd1);
                else chk("latch_din", {23'd0, din_stable, run_din}, {23'd0, 1'b1, 4'h0, exp_q[0].addr});
                latched     = 1'b1;
                last_active = 2'b11;
            end
            2'b00: begin
                gap_len = run_len;
                if (last_active == 2'b11) chk("gap1_len", 32'(run_len), 32'd1);
            end
            default: begin
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("xfer_kind", 32'(run_code), cur_e.rd ? 32'd1 : 32'd2);
                    chk("xfer_len", 32'(run_len), 32'(HOLD));
                    chk("xfer_din", {23'd0, din_stable, run_din},
                        {23'd0, 1'b1, cur_e.rd ? 8'h00 : cur_e.data});
                    chk("xfer_latched", 32'(latched), 32'(!cur_e.skip));
                    if (cur_e.rd)
                        chk("rd_result", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, cur_e.data});
                end
                latched     = 1'b0;
                last_active = run_code;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            run_code    = 2'b00;
            run_len     = 0;
            gap_len     = 0;
            prev_pins   = 2'b00;
            last_active = 2'b00;
            latched     = 1'b0;
        end else begin
            cur = {bdir, bc1};
            if (rd_valid) begin
                rdv_cnt++;
                chk("rd_valid_timing", {30'd0, prev_pins == 2'b01, cur == 2'b00}, 32'd3);
            end
            if (run_len > 0 && cur == run_code) begin
                run_len++;
                if (din !== run_din) din_stable = 1'b0;
            end else begin
                if (run_len > 0) close_run();
                if (cur == 2'b11 && btb_mode && (last_active == 2'b10 || last_active == 2'b01))
                    chk("btb_gap", 32'(gap_len), 32'd2);
                run_code   = cur;
                run_len    = 1;
                run_din    = din;
                din_stable = 1'b1;
            end
            prev_pins = cur;
        end
    end

    task automatic push(input logic rd, input logic [3:0] a, input logic [7:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rd    = rd;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        chk("push_accept", 32'(req_ready), 32'd1);
        if (req_ready) model_accept(rd, a, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        chk("pending_expect", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_seq [8];
        logic [3:0]  a;
        int          w, n, base, activity;

        for (int i = 0; i < 16; i++) begin
            wrap_regs[i]  = 8'($urandom);
            model_regs[i] = wrap_regs[i];
        end
        wrap_regs[14]  = 8'hA5;
        model_regs[14] = 8'hA5;

        repeat (3) @(negedge clk);
        chk("reset_state", {11'd0, bdir, bc1, din, rd_valid, rd_data, busy, req_ready}, 32'd1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single write: cycle-exact {busy, bdir, bc1, din} after acceptance.
        exp_seq = '{11'h400, 11'h707, 11'h707, 11'h400, 11'h638, 11'h638, 11'h400, 11'h000};
        push(1'b0, 4'd7, 8'h38, w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("write_seq", {21'd0, busy, bdir, bc1, din}, {21'd0, exp_seq[i]});
        end
        wait_idle();

        base = rdv_cnt;
        push(1'b1, 4'd14, 8'h00, w);
        wait_idle();
        chk("read_pulses", 32'(rdv_cnt - base), 32'd1);

        base = rdv_cnt;
        push(1'b0, 4'd0, 8'h55, w);
        push(1'b1, 4'd0, 8'h00, w);
        wait_idle();
        chk("mixed_pulses", 32'(rdv_cnt - base), 32'd1);

        base = lat_cnt;
        push(1'b0, 4'd8, 8'h12, w);
        push(1'b0, 4'd8, 8'h34, w);
        wait_idle();
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
        chk("skip_latches", 32'(lat_cnt - base), 32'd1);
`else
        chk("skip_latches", 32'(lat_cnt - base), 32'd2);
`endif

        // One request drains into the FSM at once, so DEPTH+1 back-to-back pushes fit before a stall.
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(1'b0, 4'(i + 1), 8'($urandom), w);
            if (i <= DEPTH) chk("full_no_stall", 32'(w), 32'd0);
            else            chk("full_stall", 32'(w > 0), 32'd1);
            if (i == DEPTH) btb_mode = 1'b1;
        end
        wait_idle();
        btb_mode = 1'b0;

        // Reset in the middle of a write discards the queue and drops the pins at once.
        push(1'b0, 4'd9, 8'h3C, w);
        push(1'b1, 4'd2, 8'h00, w);
        push(1'b0, 4'd4, 8'h11, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ({bdir, bc1} != 2'b10 && n < 100);
        chk("reach_write", 32'({bdir, bc1}), 32'd2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rst_abort", {27'd0, bdir, bc1, busy, req_ready, rd_valid}, 32'b00010);
        rst_n    = 1'b1;
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (bdir || bc1 || busy || rd_valid) activity++;
        end
        chk("rst_no_replay", 32'(activity), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_regs[i] = wrap_regs[i];
`ifdef JT49_BUS_SEQ_SKIPLATCH_EN
        m_last_addr  = 4'hF;
        m_last_valid = 1'b0;
`endif
        mon_en = 1'b1;

        a = 4'd3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) a = 4'($urandom_range(0, 15));
            push(1'($urandom_range(0, 1)), a, 8'($urandom), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
